video_frame_checker: RTL and testbench
======================================

// Module: video_frame_checker
// PURPOSE
// Sink-side checker for the de/pix raster stream from the video generator. Finds frame boundaries
// from de gaps, recovers pixel coordinates, and checks line/frame geometry and the
// one-pixel border pattern against the parameters. Sits at the video output or in a loopback bench.
// It raises lock once consecutive frames are clean.
// PARAMETERS
// NumColTotal   10'd800  expected ce-cycles per line (de rise to de rise)
// NumColActive  10'd640  expected de-high run length per line
// NumRowTotal   10'd525  total lines per frame (documentation/bench only, not checked)
// NumRowActive  10'd480  expected active lines per frame
// LockFrames    4'd2     consecutive clean frames required before locked_o asserts
// PORTS
// clk_i          in   1   clock
// rst_i          in   1   synchronous active-high reset
// ce_i           in   1   pixel clock enable; inputs sampled only when high
// de_i           in   1   data enable from source
// pix_i          in   1   pixel value from source
// err_clr_i      in   1   clears err_o sticky bits
// pix_valid_o    out  1   registered copy of sampled de_i while in ACTIVE
// col_o          out  10  column of pixel flagged by pix_valid_o
// row_o          out  10  row of pixel flagged by pix_valid_o
// frame_start_o  out  1   one-cycle pulse: first pixel of frame (row 0, col 0) sampled
// frame_ok_o     out  1   one-cycle pulse: frame ended with no errors
// locked_o       out  1   LockFrames consecutive clean frames seen, no error since
// err_o          out  4   sticky: [0] run length, [1] line period, [2] row count, [3] pixel
// BEHAVIOUR
// - Reset: state SEARCH, all counters 0, all outputs 0.
// - ce_i=0: all state and counters hold. Pulse outputs and pix_valid_o are 0 on that cycle.
// - Outputs are registered, with 1 ce-cycle latency from the sampled de_i/pix_i.
// - gap_cnt counts consecutive de_i=0 samples and saturates at NumColTotal.
//   vblank = (gap_cnt==NumColTotal). A horizontal blank never reaches this value.
// - per_cnt counts samples since the last de rise and saturates at 1023.
//   run_cnt counts the current de-high run.
// - FSM:
//   SEARCH: wait for vblank, then go to ARMED.
//   ARMED: on de rise, set row=0 and col=0, pulse frame_start_o, go to ACTIVE.
//   ACTIVE: de rise starts a new line; row increments on every rise except the first.
//     col increments on every de=1 sample. vblank in ACTIVE means frame end: run the row
//     check, pulse frame_ok_o if the frame was clean, then go to ARMED.
// - Checks, in ACTIVE only:
//   [0] de fall with run_cnt != NumColActive.
//   [1] de rise, other than the first of the frame, with per_cnt != NumColTotal.
//   [2] de rise when row==NumRowActive-1 (too many lines), or frame end with row != NumRowActive-1.
//   [3] pix_i != (row==0 || row==NumRowActive-1 || col==0 || col==NumColActive-1) on a de=1 sample.
// - On any error: set the err_o bit(s), clear locked_o and the good-frame count, go to SEARCH.
//   No frame_ok_o pulse for that frame.
// - good_cnt increments on frame_ok_o and saturates. locked_o=1 when good_cnt>=LockFrames.
// - err_clr_i clears err_o. If a new error occurs in the same cycle, the new error's bit is set.
// - Multiple errors on one sample set all of the corresponding bits.
// - Reset mid-frame returns to SEARCH. The first frame after reset is never reported,
//   because a full vblank must be seen first.
// TESTING (bench params 20/16/12/8, LockFrames=2, ce_i=1 unless stated)
// - Loopback with the video generator, same params: frame_start_o every 240 cycles, err_o=0,
//   frame_ok_o pulses from frame 2 on, locked_o=1 after the second frame_ok_o.
// - Coordinates: pix_valid_o high for 16 cycles per line; col_o runs 0..15, row_o 0..7;
//   last valid pixel is (15,7).
// - Run fault: one line with de high 15 samples -> err_o[0]=1, locked_o=0; relock after 1 vblank + 2 frames.
// - Pixel fault: force pix_i=0 at (0,3) -> err_o[3]=1, no frame_ok_o for that frame.
// - Row fault: 9 active lines -> err_o[2] on the 9th de rise; only 7 lines -> err_o[2] at vblank.
// - ce_i toggling 1/0 with stretched source: same results as above; err_clr_i together with a
//   new bit-1 fault -> err_o=4'b0010.
// - Mid-frame rst_i: next frame_start_o only after a full vblank.

Source files
------------

// File: rtl/video_frame_checker_if.sv
// rtl/video_frame_checker_if.sv - raster input and checker result bundle for video_frame_checker
interface video_frame_checker_if;
    logic       ce_i;
    logic       de_i;
    logic       pix_i;
    logic       err_clr_i;
    logic       pix_valid_o;
    logic [9:0] col_o;
    logic [9:0] row_o;
    logic       frame_start_o;
    logic       frame_ok_o;
    logic       locked_o;
    logic [3:0] err_o;

    modport master (
        output ce_i, de_i, pix_i, err_clr_i,
        input  pix_valid_o, col_o, row_o, frame_start_o, frame_ok_o, locked_o, err_o
    );

    modport slave (
        input  ce_i, de_i, pix_i, err_clr_i,
        output pix_valid_o, col_o, row_o, frame_start_o, frame_ok_o, locked_o, err_o
    );
endinterface

// File: rtl/video_frame_checker.sv
// rtl/video_frame_checker.sv - de/pix raster sink: frame sync, coordinate recovery, geometry/border checks, lock
module video_frame_checker #(
    parameter logic [9:0] NumColTotal  = 10'd800,
    parameter logic [9:0] NumColActive = 10'd640,
    parameter logic [9:0] NumRowTotal  = 10'd525,
    parameter logic [9:0] NumRowActive = 10'd480,
    parameter logic [3:0] LockFrames   = 4'd2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    video_frame_checker_if.slave  bus
);
    typedef enum logic [1:0] {SEARCH, ARMED, ACTIVE} state_t;

    // Row total only describes the source; a frame is delimited by de gaps alone.
    if (NumRowTotal < NumRowActive) begin : g_row_params_inconsistent
    end

    state_t     state;
    logic       de_q;
    logic [9:0] gap_cnt;
    logic [9:0] per_cnt;
    logic [9:0] run_cnt;
    logic [9:0] row_q;
    logic [9:0] col_q;
    logic [3:0] good_cnt;
    logic       pix_valid_q;
    logic       frame_start_q;
    logic       frame_ok_q;
    logic       locked_q;
    logic [3:0] err_q;

    logic       rise;
    logic       fall;
    logic       vblank;
    logic       start;
    logic       in_frame;
    logic       frame_end;
    logic       border;
    logic       any_err;
    logic [9:0] cur_col;
    logic [9:0] cur_row;
    logic [3:0] new_err;
    logic [3:0] good_nxt;

    always_comb begin
        rise      = bus.de_i & ~de_q;
        fall      = ~bus.de_i & de_q;
        vblank    = (gap_cnt == NumColTotal);
        start     = (state == ARMED) && rise;
        // The frame-start sample is checked like any other active pixel.
        in_frame  = (state == ACTIVE) || start;
        frame_end = (state == ACTIVE) && vblank;
        cur_col   = rise ? 10'd0 : col_q + 10'd1;
        cur_row   = start ? 10'd0 : (rise ? row_q + 10'd1 : row_q);
        border    = (cur_row == 10'd0) || (cur_row == NumRowActive - 10'd1) ||
                    (cur_col == 10'd0) || (cur_col == NumColActive - 10'd1);
        new_err   = 4'd0;
        if (state == ACTIVE) begin
            new_err[0] = fall && (run_cnt != NumColActive);
            new_err[1] = rise && (per_cnt != NumColTotal);
            new_err[2] = (rise && (row_q == NumRowActive - 10'd1)) ||
                         (frame_end && (row_q != NumRowActive - 10'd1));
        end
        if (in_frame) begin
            new_err[3] = bus.de_i && (bus.pix_i != border);
        end
        any_err  = |new_err;
        good_nxt = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= SEARCH;
            de_q          <= 1'b0;
            gap_cnt       <= 10'd0;
            per_cnt       <= 10'd0;
            run_cnt       <= 10'd0;
            row_q         <= 10'd0;
            col_q         <= 10'd0;
            good_cnt      <= 4'd0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_ok_q    <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 4'd0;
        end else begin
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_ok_q    <= 1'b0;
            if (bus.err_clr_i) begin
                err_q <= 4'd0;
            end
            if (bus.ce_i) begin
                de_q    <= bus.de_i;
                gap_cnt <= bus.de_i ? 10'd0 :
                           (gap_cnt == NumColTotal ? gap_cnt : gap_cnt + 10'd1);
                per_cnt <= rise ? 10'd1 : (per_cnt == 10'h3FF ? per_cnt : per_cnt + 10'd1);
                if (bus.de_i) begin
                    run_cnt <= rise ? 10'd1 : (run_cnt == 10'h3FF ? run_cnt : run_cnt + 10'd1);
                end
                if (in_frame && bus.de_i && !any_err) begin
                    col_q       <= cur_col;
                    row_q       <= cur_row;
                    pix_valid_q <= 1'b1;
                end
                // A clear in the same cycle as a new fault must not hide the fault.
                err_q <= (bus.err_clr_i ? 4'd0 : err_q) | new_err;
                if (any_err) begin
                    state    <= SEARCH;
                    good_cnt <= 4'd0;
                    locked_q <= 1'b0;
                end else begin
                    case (state)
                        SEARCH: if (vblank) state <= ARMED;
                        ARMED: if (rise) begin
                            state         <= ACTIVE;
                            frame_start_q <= 1'b1;
                        end
                        ACTIVE: if (frame_end) begin
                            state      <= ARMED;
                            frame_ok_q <= 1'b1;
                            good_cnt   <= good_nxt;
                            locked_q   <= (good_nxt >= LockFrames);
                        end
                        default: state <= SEARCH;
                    endcase
                end
            end
        end
    end

    assign bus.pix_valid_o   = pix_valid_q;
    assign bus.col_o         = col_q;
    assign bus.row_o         = row_q;
    assign bus.frame_start_o = frame_start_q;
    assign bus.frame_ok_o    = frame_ok_q;
    assign bus.locked_o      = locked_q;
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_video_frame_checker.sv
// tb/tb_video_frame_checker.sv - scoreboard bench for video_frame_checker with geometry and pixel faults
module tb_video_frame_checker;
    localparam logic [9:0] CT = 10'd20;
    localparam logic [9:0] CA = 10'd16;
    localparam logic [9:0] RT = 10'd12;
    localparam logic [9:0] RA = 10'd8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_frame_checker_if bus();

    video_frame_checker #(
        .NumColTotal (CT),
        .NumColActive(CA),
        .NumRowTotal (RT),
        .NumRowActive(RA),
        .LockFrames  (4'd2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int          checks = 0;
    int          failures = 0;
    logic [19:0] pix_q[$];
    logic [19:0] exp_pix;
    int          exp_starts = 0;
    int          exp_oks = 0;
    int          seen_starts = 0;
    int          seen_oks = 0;
    int          exp_good = 0;
    logic [3:0]  exp_err = 4'd0;
    bit          vb_seen = 0;
    bit          stretch = 0;
    bit          per_chk = 0;
    int          cyc = 0;
    int          last_fs = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pix_valid_o) begin
                if (pix_q.size() == 0) begin
                    check("pix_extra", pix_q.size(), 1);
                end else begin
                    exp_pix = pix_q.pop_front();
                    check("pix", {bus.col_o, bus.row_o}, exp_pix);
                end
            end
            if (bus.frame_start_o) begin
                seen_starts++;
                if (per_chk && last_fs >= 0) check("fs_period", cyc - last_fs, 240);
                last_fs = cyc;
            end
            if (bus.frame_ok_o) seen_oks++;
        end
    end

    function automatic bit is_border(int r, int c);
        return (r == 0) || (r == int'(RA) - 1) || (c == 0) || (c == int'(CA) - 1);
    endfunction

    task automatic drive(input logic de, input logic pix, input logic clr);
        if (stretch) begin
            bus.ce_i      = 1'b0;
            bus.de_i      = 1'($urandom);
            bus.pix_i     = 1'($urandom);
            bus.err_clr_i = 1'b0;
            @(posedge clk); #1;
        end
        bus.ce_i      = 1'b1;
        bus.de_i      = de;
        bus.pix_i     = pix;
        bus.err_clr_i = clr;
        @(posedge clk); #1;
        bus.err_clr_i = 1'b0;
    endtask

    // One source frame of RT lines; faults are injected per argument (-1 = none).
    task automatic run_frame(input int lines, input int short_line, input int long_line,
                             input int fault_row, input int fault_col, input int rst_line,
                             input bit clr_on_fault);
        bit         alive;
        bit         de;
        bit         fault;
        logic       pix;
        logic [3:0] e;
        int         run;
        int         len;
        alive = vb_seen;
        if (alive) exp_starts++;
        for (int r = 0; r < int'(RT); r++) begin
            run = (r < lines) ? ((r == short_line) ? 15 : int'(CA)) : 0;
            len = (r == long_line) ? int'(CT) + 1 : int'(CT);
            if (r == rst_line) begin
                bus.ce_i = 1'b1;
                bus.de_i = 1'b0;
                rst      = 1'b1;
                @(posedge clk); #1;
                rst      = 1'b0;
                alive    = 0;
                exp_err  = 4'd0;
                exp_good = 0;
                check("rst_err", bus.err_o, 4'd0);
                check("rst_lock", bus.locked_o, 1'b0);
            end
            for (int c = 0; c < len; c++) begin
                de    = (c < run);
                fault = 0;
                pix   = is_border(r, c) ^ (r == fault_row && c == fault_col);
                if (alive) begin
                    e = 4'd0;
                    if (de && r == fault_row && c == fault_col) e[3] = 1'b1;
                    if (de && c == 0 && r == int'(RA)) e[2] = 1'b1;
                    if (de && c == 0 && r > 0 && r - 1 == long_line) e[1] = 1'b1;
                    if (!de && c == run && run != 0 && run != int'(CA)) e[0] = 1'b1;
                    if (e != 4'd0) begin
                        alive    = 0;
                        fault    = 1;
                        exp_err  = (clr_on_fault ? 4'd0 : exp_err) | e;
                        exp_good = 0;
                    end else if (de) begin
                        pix_q.push_back({10'(c), 10'(r)});
                    end
                end
                drive(de, pix, fault && clr_on_fault);
            end
        end
        if (alive) begin
            if (lines == int'(RA)) begin
                exp_oks++;
                exp_good++;
            end else begin
                exp_err[2] = 1'b1;
                exp_good   = 0;
            end
        end
        vb_seen = 1;
        @(negedge clk); #1;
        check("err", bus.err_o, exp_err);
        check("lock", bus.locked_o, exp_good >= 2);
        check("starts", seen_starts, exp_starts);
        check("oks", seen_oks, exp_oks);
    endtask

    task automatic clear_errors();
        drive(1'b0, 1'b0, 1'b1);
        exp_err = 4'd0;
        @(negedge clk); #1;
        check("clr", bus.err_o, 4'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ce_i      = 1'b0;
        bus.de_i      = 1'b0;
        bus.pix_i     = 1'b0;
        bus.err_clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_valid", bus.pix_valid_o, 1'b0);
        check("rst_col", bus.col_o, 10'd0);
        check("rst_row", bus.row_o, 10'd0);
        check("rst_fstart", bus.frame_start_o, 1'b0);
        check("rst_fok", bus.frame_ok_o, 1'b0);
        check("rst_locked", bus.locked_o, 1'b0);
        check("rst_err0", bus.err_o, 4'd0);
        rst = 1'b0;

        per_chk = 1;
        repeat (4) run_frame(8, -1, -1, -1, -1, -1, 0);
        per_chk = 0;

        run_frame(8, 2, -1, -1, -1, -1, 0);
        repeat (2) run_frame(8, -1, -1, -1, -1, -1, 0);
        run_frame(8, -1, -1, 3, 0, -1, 0);
        clear_errors();

        run_frame(9, -1, -1, -1, -1, -1, 0);
        run_frame(8, -1, -1, -1, -1, -1, 0);
        run_frame(7, -1, -1, -1, -1, -1, 0);
        clear_errors();

        stretch = 1;
        repeat (2) run_frame(8, -1, -1, -1, -1, -1, 0);
        run_frame(8, -1, -1, 3, 0, -1, 0);
        run_frame(8, -1, 2, -1, -1, -1, 1);
        run_frame(8, -1, -1, -1, -1, -1, 0);

        stretch = 0;
        run_frame(8, -1, -1, -1, -1, 4, 0);
        repeat (2) run_frame(8, -1, -1, -1, -1, -1, 0);

        check("sb_empty", pix_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
